// File: rtl/uart_fifo_rd_sequencer.sv
// Read-side sequencer for the UART FIFO: issues active-low read strobes, absorbs the
// FIFO's two-cycle read latency and presents popped bytes as a valid/ready stream.
module uart_fifo_rd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  byte_count
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int OW = $clog2(BUF_DEPTH) + 1;
  localparam int LW = OW + 2;

  // vld_pipe[1] = read issued last cycle, vld_pipe[2] = data on fifo_dout now
  logic [2:1]            vld_pipe;
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [OW-1:0]         occ;
  logic                  issue, push, pop;
  logic [LW-1:0]         load, limit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push    = vld_pipe[2];
  assign pop     = m_valid & m_ready;
  assign m_valid = (occ != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign busy    = vld_pipe[1] | vld_pipe[2] | m_valid;

  // Reserve a buffer slot for every read in flight; a pop this cycle frees one.
  assign load      = LW'(occ) + LW'(vld_pipe[1]) + LW'(vld_pipe[2]);
  assign limit     = LW'(BUF_DEPTH) + LW'(pop);
  assign issue     = enable & ~fifo_empty & ~reset & (load < limit);
  assign fifo_rd_n = ~issue;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[1], issue};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= fifo_dout;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      occ <= occ + OW'(1);
      else if (!push && pop) occ <= occ - OW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    byte_count <= '0;
    else if (pop) byte_count <= byte_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_uart_fifo_rd_sequencer.sv
// Bench for uart_fifo_rd_sequencer: a queue-based FIFO with two-cycle read latency
// feeds the DUT; delivered bytes are scoreboarded against the write order.
module tb_uart_fifo_rd_sequencer;
  localparam int DW = 8;
  localparam int BD = 3;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset, enable, m_ready;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_n, m_valid, busy;
  logic [DW-1:0] m_data;
  logic [CW-1:0] byte_count;

  uart_fifo_rd_sequencer #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_n(fifo_rd_n), .fifo_dout(fifo_dout), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .busy(busy), .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  logic [DW-1:0] wq[$], fq[$], exp_q[$];
  logic [DW-1:0] d1 = '0;
  bit  rd_seen = 1'b0;
  int  rd_log[$], acc_log[$];
  int  rd_tot = 0, pop_tot = 0, max_out = 0, model_cnt = 0, n_valid = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] b);
    wq.push_back(b);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (wq.size() == 0 && fq.size() == 0 && exp_q.size() == 0 && !busy) break;
      step();
    end
    chk({tag, "_drain"}, exp_q.size() + fq.size() + wq.size(), 0);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // FIFO model: strobe seen in cycle t pops at edge t+1, byte shows on fifo_dout in t+2
  always @(posedge clock) begin
    #1;
    fifo_dout = d1;
    if (rd_seen) begin
      if (fq.size() == 0) begin
        chk("fifo_underflow", 1, 0);
        d1 = DW'($urandom);
      end else d1 = fq.pop_front();
    end else d1 = DW'($urandom);
    while (wq.size() != 0) begin
      fq.push_back(wq[0]);
      exp_q.push_back(wq[0]);
      void'(wq.pop_front());
    end
    fifo_empty = (fq.size() == 0);
  end

  // Monitor: strobes, scoreboard, byte count model, outstanding-read bound
  always @(negedge clock) begin
    if (reset) begin
      rd_seen = 1'b0;
      exp_q.delete();
      pop_tot = rd_tot;
      model_cnt = 0;
    end else begin
      rd_seen = !fifo_rd_n;
      if (rd_seen) begin
        rd_tot++;
        rd_log.push_back(cyc);
      end
      if (m_valid) n_valid++;
      else chk("idle_data_zero", m_data, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("spurious_byte", 1, 0);
        else chk("order", m_data, exp_q.pop_front());
        pop_tot++;
        model_cnt++;
        acc_log.push_back(cyc);
      end
      if (rd_tot - pop_tot > max_out) max_out = rd_tot - pop_tot;
    end
  end

  initial begin
    int s_rd, s_acc, s_val, nbytes;
    logic [DW-1:0] b0;
    reset = 1'b1; enable = 1'b0; m_ready = 1'b0;
    step(); step();
    chk("rst_rd_n", fifo_rd_n, 1);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", byte_count, 0);
    reset = 1'b0;
    step();

    // 5-byte burst: back-to-back strobes, first byte 3 cycles after first strobe
    enable = 1'b1; m_ready = 1'b1;
    s_rd = rd_log.size(); s_acc = acc_log.size();
    for (int i = 1; i <= 5; i++) push(DW'(i));
    drain("burst5", 40);
    chk("burst5_strobes", rd_log.size() - s_rd, 5);
    chk("burst5_pops", acc_log.size() - s_acc, 5);
    if (rd_log.size() >= s_rd + 5 && acc_log.size() >= s_acc + 5) begin
      chk("burst5_strobe_span", rd_log[s_rd+4] - rd_log[s_rd], 4);
      chk("burst5_latency", acc_log[s_acc] - rd_log[s_rd], 3);
      chk("burst5_pop_span", acc_log[s_acc+4] - acc_log[s_acc], 4);
    end
    chk("burst5_count", byte_count, 5);
    chk("burst5_busy", busy, 0);

    // Consumer stalled: only BUF_DEPTH reads may be outstanding
    m_ready = 1'b0;
    s_rd = rd_log.size(); s_acc = acc_log.size();
    b0 = DW'($urandom);
    push(b0);
    for (int i = 1; i < 10; i++) push(DW'($urandom));
    for (int i = 0; i < 12; i++) step();
    chk("stall_strobes", rd_log.size() - s_rd, BD);
    chk("stall_valid", m_valid, 1);
    chk("stall_head", m_data, b0);
    m_ready = 1'b1;
    drain("stall", 60);
    chk("stall_total_strobes", rd_log.size() - s_rd, 10);
    chk("stall_total_pops", acc_log.size() - s_acc, 10);

    // m_ready alternating
    s_acc = acc_log.size();
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    for (int i = 0; i < 80; i++) begin
      m_ready = i[0];
      if (wq.size() == 0 && exp_q.size() == 0 && !busy) break;
      step();
    end
    m_ready = 1'b1;
    chk("toggle_pops", acc_log.size() - s_acc, 8);
    chk("toggle_left", exp_q.size() + fq.size(), 0);
    chk("toggle_no_overflow", max_out > BD, 0);

    // enable dropped in the cycle after the 2nd strobe
    s_rd = rd_log.size(); s_acc = acc_log.size();
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    step(); step(); step();
    enable = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("endrop_strobes", rd_log.size() - s_rd, 2);
    chk("endrop_pops", acc_log.size() - s_acc, 2);
    chk("endrop_fifo_left", fq.size(), 4);
    chk("endrop_busy", busy, 0);
    enable = 1'b1;
    drain("endrop", 40);
    chk("endrop_total_pops", acc_log.size() - s_acc, 6);

    // Single byte
    s_rd = rd_log.size(); s_acc = acc_log.size();
    push(8'hA5);
    step(); step();
    chk("single_empty", fifo_empty, 1);
    for (int i = 0; i < 8; i++) step();
    chk("single_strobes", rd_log.size() - s_rd, 1);
    chk("single_pops", acc_log.size() - s_acc, 1);
    if (acc_log.size() > s_acc) chk("single_count", byte_count, 16'(model_cnt));

    // Reset with two reads in flight
    push(DW'($urandom)); push(DW'($urandom));
    step(); step(); step();
    reset = 1'b1;
    #1;
    chk("midrst_rd_n", fifo_rd_n, 1);
    chk("midrst_valid", m_valid, 0);
    chk("midrst_data", m_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", byte_count, 0);
    step();
    reset = 1'b0;
    s_rd = rd_log.size(); s_val = n_valid;
    for (int i = 0; i < 8; i++) step();
    chk("postrst_no_valid", n_valid - s_val, 0);
    chk("postrst_no_strobe", rd_log.size() - s_rd, 0);

    // Randomized enable / m_ready / write traffic
    for (int i = 0; i < 300; i++) begin
      enable  = ($urandom_range(3) != 0);
      m_ready = $urandom_range(1);
      if ($urandom_range(2) == 0) push(DW'($urandom));
      step();
    end
    enable = 1'b1; m_ready = 1'b1;
    drain("random", 300);
    chk("random_count", byte_count, 16'(model_cnt));
    chk("random_no_overflow", max_out > BD, 0);

    // Counter wrap
    nbytes = 65535 - model_cnt;
    for (int i = 0; i < nbytes; i++) push(DW'($urandom));
    drain("wrap_fill", 70000);
    chk("wrap_ffff", byte_count, 16'hFFFF);
    push(DW'($urandom));
    drain("wrap_last", 20);
    chk("wrap_zero", byte_count, 16'h0000);
    chk("final_no_overflow", max_out > BD, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
